// File: rtl/divider_seq.sv
// divider_seq
// ----------------------------------------------------------------------------
// Multi-cycle restoring divider. An accepted start captures the operands; the
// core then retires one quotient bit per clock, and the results are published
// in a single cycle flagged by a one-cycle done pulse. Quotient, remainder and
// the two flags hold their values until the next division completes.
//
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   -> is_signed selects two's-complement truncating division
//   undefined -> is_signed is ignored, every division is unsigned, overflow
//                never asserts; latency is identical in both builds
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high; returns to IDLE, clears outputs
//   start      in   division request, honoured only while busy is low
//   is_signed  in   operand interpretation, sampled together with start
//   dividend   in   [WIDTH-1:0] numerator, captured on an accepted start
//   divisor    in   [WIDTH-1:0] denominator, captured on an accepted start
//   busy       out  high from acceptance through the done cycle
//   done       out  one-cycle pulse; results below are valid in that cycle
//   quotient   out  [WIDTH-1:0] registered quotient
//   remainder  out  [WIDTH-1:0] registered remainder
//   div_zero   out  divisor was zero
//   overflow   out  signed most-negative divided by -1
//
// Timing: start sampled at edge N gives done in the cycle after edge
// N+WIDTH+1 (N+1 for a zero divisor).
// ----------------------------------------------------------------------------
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] dvsr_q,      dvsr_d;
    logic [WIDTH-1:0] dvd_raw_q,   dvd_raw_d;
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             dz_pend_q,   dz_pend_d;
    logic             ovf_pend_q,  ovf_pend_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q,  div_zero_d;
    logic             overflow_q,  overflow_d;
    logic             done_q,      done_d;

    logic             signed_op;
    logic             ovf_detect;

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    assign signed_op  = is_signed;
    assign ovf_detect = is_signed && (dividend == MOST_NEG) && (divisor == '1);
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign signed_op        = 1'b0;
    assign ovf_detect       = 1'b0;
`endif

    // Operand signs and magnitudes. The most-negative value negates to itself,
    // which read as unsigned is exactly its magnitude, so no special case.
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    assign dvd_neg = signed_op & dividend[WIDTH-1];
    assign dvs_neg = signed_op & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? ('0 - dividend) : dividend;
    assign dvs_mag = dvs_neg ? ('0 - divisor)  : divisor;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and trial-subtract. The partial remainder is always below twice the
    // divisor, so WIDTH+1 bits hold it and the top bit of the difference is
    // a reliable sign.
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    assign partial = {rem_q, work_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dvsr_q};

    // Next-state logic: capture in IDLE, iterate in RUN, publish in DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        work_d      = work_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        dvd_raw_d   = dvd_raw_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_pend_d   = dz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is still part of the busy window, so a
                // start arriving alongside done is refused.
                if (start && !done_q) begin
                    dvd_raw_d  = dividend;
                    work_d     = dvd_mag;
                    rem_d      = '0;
                    dvsr_d     = dvs_mag;
                    neg_quo_d  = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    dz_pend_d  = (divisor == '0);
                    ovf_pend_d = ovf_detect;
                    if (divisor == '0) begin
                        state_d = DONE;
                        count_d = '0;
                    end else begin
                        state_d = RUN;
                        count_d = COUNT_INIT;
                    end
                end
            end

            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d  = diff[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = partial[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - COUNT_ONE;
                if (count_q == COUNT_ONE) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Most-negative / -1 needs no override: the magnitude quotient
                // already has the most-negative bit pattern and the remainder
                // is zero, only the flag has to be raised.
                done_d     = 1'b1;
                div_zero_d = dz_pend_q;
                overflow_d = ovf_pend_q;
                if (dz_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_raw_q;
                end else begin
                    quotient_d  = neg_quo_q ? ('0 - work_q) : work_q;
                    remainder_d = neg_rem_q ? ('0 - rem_q)  : rem_q;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            dvd_raw_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_pend_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            dvd_raw_q   <= dvd_raw_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_pend_q   <= dz_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE) | done_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule
